mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access (MEM) stage of the CPU pipeline, located between the execute stage and the general-purpose register file. For ALU results, it registers the value and forwards it to the register file write port. For loads and stores, it performs a single-word transaction on the data bus with a ready handshake and holds the pipeline while that transaction is outstanding. For loads, it writes the returned data back to the register file. Its write outputs connect directly to the register file's active-low write port.

## Interface
Parameters:
- WORD_W, 32, data word width
- REG_ADDR_W, 5, register address width
- BUS_ADDR_W, 30, bus word-address width (WORD_W byte address >> 2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ex_en  in  1  execute-stage output valid
- ex_mem_op  in  2  0=NOP (ALU result), 1=LOAD, 2=STORE, 3=reserved (treated as NOP)
- ex_addr  in  WORD_W  byte address for LOAD/STORE
- ex_wr_data  in  WORD_W  store data
- ex_out  in  WORD_W  ALU result
- ex_dst_addr  in  REG_ADDR_W  destination register
- ex_dst_we_  in  1  active-low destination write request
- flush  in  1  discard pending writeback (branch/exception)
- mem_busy  out  1  stall upstream; ex_* must be held while high
- mem_miss_align  out  1  one-cycle misalignment pulse
- bus_req  out  1  bus request
- bus_rw  out  1  1=read, 0=write
- bus_addr  out  BUS_ADDR_W  word address
- bus_wr_data  out  WORD_W  write data
- bus_rd_data  in  WORD_W  read data, valid when bus_rdy high
- bus_rdy  in  1  transfer completes this cycle
- gpr_we_  out  1  active-low register-file write enable
- gpr_wr_addr  out  REG_ADDR_W  register-file write address
- gpr_wr_data  out  WORD_W  register-file write data

## Operation
- The FSM has two states: IDLE and ACCESS. Reset enters IDLE.
- **Reset values:**
  - bus_req=0, bus_rw=1, bus_addr=0, bus_wr_data=0
  - gpr_we_=1, gpr_wr_addr=0, gpr_wr_data=0
  - mem_miss_align=0
  - mem_busy=0 (combinational: mem_busy = state==ACCESS)
- **IDLE, accept when ex_en=1:**
  - NOP/reserved: gpr_wr_data<=ex_out, gpr_wr_addr<=ex_dst_addr, gpr_we_<=ex_dst_we_. Stay in IDLE.
  - LOAD/STORE with ex_addr[1:0]!=0: mem_miss_align<=1, gpr_we_<=1, no bus activity. Stay in IDLE.
  - LOAD aligned: bus_req<=1, bus_rw<=1, bus_addr<=ex_addr[31:2]; latch ex_dst_addr and ex_dst_we_. Go to ACCESS.
  - STORE aligned: bus_req<=1, bus_rw<=0, bus_addr<=ex_addr[31:2], bus_wr_data<=ex_wr_data. Go to ACCESS.
- **IDLE, ex_en=0:** gpr_we_<=1.
- **Pulses:** gpr_we_ and mem_miss_align are one-cycle pulses. They return to 1 and 0 respectively on the next edge unless re-asserted.
- **ACCESS:**
  - bus_req, bus_rw, bus_addr and bus_wr_data are held stable until bus_rdy=1 is sampled.
  - On the bus_rdy cycle: bus_req<=0 and the state returns to IDLE.
  - For a LOAD, that same edge also sets gpr_wr_data<=bus_rd_data, gpr_wr_addr<=latched dst, gpr_we_<=latched we_.
  - For a STORE, gpr_we_ stays 1.
- **Flush:** flush=1 forces gpr_we_<=1 on that edge and, in IDLE, blocks acceptance. Flush during ACCESS does not abort the bus transfer. The transfer completes, but the load writeback is suppressed: a sticky cancel bit is set and cleared on return to IDLE.
- bus_rdy is ignored outside ACCESS.

## Timing
- **NOP/ALU op** accepted at edge N: gpr write visible N+1 (1-cycle latency, one op per cycle).
- **LOAD/STORE** accepted at edge N:
  - bus_req high from N+1.
  - With bus_rdy at cycle M≥N+1, writeback is visible at M+1.
  - mem_busy is high during cycles N+1..M.
  - The next op is accepted at edge M+1.
  - Zero-wait bus: 2 cycles per memory op.
- **Misalignment:** mem_miss_align high for exactly cycle N+1.
- **Reset mid-ACCESS:** next edge forces IDLE and all reset values. bus_req drops at that edge, and no writeback occurs.
- **Simultaneous reset and flush:** reset wins.

## Test plan
- Reset, then ex_en=1, NOP, ex_out=0x12345678, dst=5, we_=0 -> next cycle gpr_we_=0, addr=5, data=0x12345678; one cycle later gpr_we_=1.
- LOAD addr=0x00000104, dst=3, bus_rdy after 2 wait cycles with rd_data=0xCAFEF00D -> bus_addr=0x41, bus_rw=1, bus_req held 3 cycles, mem_busy high 3 cycles, writeback r3=0xCAFEF00D the cycle after rdy.
- STORE addr=0x200, data=0xA5A5A5A5, immediate rdy -> one-cycle bus_req, bus_rw=0, bus_addr=0x80, bus_wr_data=0xA5A5A5A5; gpr_we_ never 0.
- LOAD addr=0x103 -> mem_miss_align one-cycle pulse, bus_req stays 0, no writeback.
- LOAD in ACCESS, flush asserted before rdy -> bus completes normally, gpr_we_ stays 1; subsequent NOP writes normally.
- Reset asserted while bus_req=1 -> next cycle bus_req=0, mem_busy=0, all outputs at reset values.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: registers ALU results for writeback and runs single-word
// load/store transfers on the data bus, stalling upstream while one is outstanding.
module mem_access_stage #(
  parameter int WORD_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int BUS_ADDR_W = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_en,
  input  logic [1:0]            ex_mem_op,
  input  logic [WORD_W-1:0]     ex_addr,
  input  logic [WORD_W-1:0]     ex_wr_data,
  input  logic [WORD_W-1:0]     ex_out,
  input  logic [REG_ADDR_W-1:0] ex_dst_addr,
  input  logic                  ex_dst_we_,
  input  logic                  flush,
  output logic                  mem_busy,
  output logic                  mem_miss_align,
  output logic                  bus_req,
  output logic                  bus_rw,
  output logic [BUS_ADDR_W-1:0] bus_addr,
  output logic [WORD_W-1:0]     bus_wr_data,
  input  logic [WORD_W-1:0]     bus_rd_data,
  input  logic                  bus_rdy,
  output logic                  gpr_we_,
  output logic [REG_ADDR_W-1:0] gpr_wr_addr,
  output logic [WORD_W-1:0]     gpr_wr_data
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  state_t                  state, state_n;
  logic                    bus_req_n, bus_rw_n;
  logic [BUS_ADDR_W-1:0]   bus_addr_n;
  logic [WORD_W-1:0]       bus_wr_data_n;
  logic                    gpr_we_n_, miss_align_n;
  logic [REG_ADDR_W-1:0]   gpr_wr_addr_n;
  logic [WORD_W-1:0]       gpr_wr_data_n;
  logic                    is_load, is_load_n;
  logic [REG_ADDR_W-1:0]   lat_dst, lat_dst_n;
  logic                    lat_we_, lat_we_n_;
  logic                    cancel, cancel_n;

  assign mem_busy = (state == ACCESS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bus_req        <= 1'b0;
      bus_rw         <= 1'b1;
      bus_addr       <= '0;
      bus_wr_data    <= '0;
      gpr_we_        <= 1'b1;
      gpr_wr_addr    <= '0;
      gpr_wr_data    <= '0;
      mem_miss_align <= 1'b0;
      is_load        <= 1'b0;
      lat_dst        <= '0;
      lat_we_        <= 1'b1;
      cancel         <= 1'b0;
    end else begin
      state          <= state_n;
      bus_req        <= bus_req_n;
      bus_rw         <= bus_rw_n;
      bus_addr       <= bus_addr_n;
      bus_wr_data    <= bus_wr_data_n;
      gpr_we_        <= gpr_we_n_;
      gpr_wr_addr    <= gpr_wr_addr_n;
      gpr_wr_data    <= gpr_wr_data_n;
      mem_miss_align <= miss_align_n;
      is_load        <= is_load_n;
      lat_dst        <= lat_dst_n;
      lat_we_        <= lat_we_n_;
      cancel         <= cancel_n;
    end
  end

  // gpr_we_ and mem_miss_align default to their idle levels so they act as pulses
  always_comb begin
    state_n       = state;
    bus_req_n     = bus_req;
    bus_rw_n      = bus_rw;
    bus_addr_n    = bus_addr;
    bus_wr_data_n = bus_wr_data;
    gpr_we_n_     = 1'b1;
    gpr_wr_addr_n = gpr_wr_addr;
    gpr_wr_data_n = gpr_wr_data;
    miss_align_n  = 1'b0;
    is_load_n     = is_load;
    lat_dst_n     = lat_dst;
    lat_we_n_     = lat_we_;
    cancel_n      = cancel;

    case (state)
      IDLE: begin
        if (ex_en && !flush) begin
          if (ex_mem_op == OP_LOAD || ex_mem_op == OP_STORE) begin
            if (ex_addr[1:0] != 2'b00) begin
              miss_align_n = 1'b1;
            end else begin
              state_n    = ACCESS;
              bus_req_n  = 1'b1;
              bus_rw_n   = (ex_mem_op == OP_LOAD);
              bus_addr_n = ex_addr[BUS_ADDR_W+1:2];
              is_load_n  = (ex_mem_op == OP_LOAD);
              lat_dst_n  = ex_dst_addr;
              lat_we_n_  = ex_dst_we_;
              cancel_n   = 1'b0;
              if (ex_mem_op == OP_STORE) begin
                bus_wr_data_n = ex_wr_data;
              end
            end
          end else begin
            gpr_wr_data_n = ex_out;
            gpr_wr_addr_n = ex_dst_addr;
            gpr_we_n_     = ex_dst_we_;
          end
        end
      end

      ACCESS: begin
        // A flush cannot abort the bus transfer, only the load's writeback
        if (flush) begin
          cancel_n = 1'b1;
        end
        if (bus_rdy) begin
          state_n   = IDLE;
          bus_req_n = 1'b0;
          cancel_n  = 1'b0;
          if (is_load && !cancel && !flush) begin
            gpr_wr_data_n = bus_rd_data;
            gpr_wr_addr_n = lat_dst;
            gpr_we_n_     = lat_we_;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a negedge monitor pops expected
// register-file writes from a scoreboard queue; scenario tasks check bus/control.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_en = 1'b0;
  logic [1:0]  ex_mem_op = 2'd0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_wr_data = '0;
  logic [31:0] ex_out = '0;
  logic [4:0]  ex_dst_addr = '0;
  logic        ex_dst_we_ = 1'b1;
  logic        flush = 1'b0;
  logic        mem_busy, mem_miss_align;
  logic        bus_req, bus_rw;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data = '0;
  logic        bus_rdy = 1'b0;
  logic        gpr_we_;
  logic [4:0]  gpr_wr_addr;
  logic [31:0] gpr_wr_data;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  localparam logic [103:0] RESET_VEC =
    {1'b0, 1'b1, 30'h0, 32'h0, 1'b1, 5'h0, 32'h0, 1'b0, 1'b0};

  mem_access_stage dut (
    .clk(clk), .reset(reset), .ex_en(ex_en), .ex_mem_op(ex_mem_op),
    .ex_addr(ex_addr), .ex_wr_data(ex_wr_data), .ex_out(ex_out),
    .ex_dst_addr(ex_dst_addr), .ex_dst_we_(ex_dst_we_), .flush(flush),
    .mem_busy(mem_busy), .mem_miss_align(mem_miss_align),
    .bus_req(bus_req), .bus_rw(bus_rw), .bus_addr(bus_addr),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy(bus_rdy),
    .gpr_we_(gpr_we_), .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data)
  );

  always #5 clk = ~clk;

  // Every register-file write pulse must match the oldest expected writeback
  always @(negedge clk) begin
    if (gpr_we_ === 1'b0) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_write: got r%0d=%h, required no write", gpr_wr_addr, gpr_wr_data);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if ({gpr_wr_addr, gpr_wr_data} !== {e.addr, e.data}) begin
          miscompares++;
          $display("[TB] FAIL writeback: got r%0d=%h, required r%0d=%h", gpr_wr_addr, gpr_wr_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not reach the end, required completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] alu, input logic [4:0] dst, input logic we_);
    ex_en = 1'b1; ex_mem_op = op; ex_addr = addr; ex_wr_data = wdata;
    ex_out = alu; ex_dst_addr = dst; ex_dst_we_ = we_;
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_drained: got %0d pending writes, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    vectors++;
    if ({bus_req, bus_rw, bus_addr, bus_wr_data, gpr_we_, gpr_wr_addr, gpr_wr_data,
         mem_miss_align, mem_busy} !== RESET_VEC) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got %h, required %h",
               {bus_req, bus_rw, bus_addr, bus_wr_data, gpr_we_, gpr_wr_addr, gpr_wr_data,
                mem_miss_align, mem_busy}, RESET_VEC);
    end
  endtask

  task automatic test_nop();
    drive_op(2'd0, 32'h0, 32'h0, 32'h12345678, 5'd5, 1'b0);
    exp_q.push_back({5'd5, 32'h12345678});
    tick();
    ex_en = 1'b0;
    vectors++;
    if (gpr_we_ !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL nop_we: got %b, required 0", gpr_we_);
    end
    tick();
    vectors++;
    if (gpr_we_ !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL nop_we_pulse: got %b, required 1", gpr_we_);
    end
    check_drained("nop");
  endtask

  task automatic test_load();
    int req_cycles = 0;
    int busy_cycles = 0;
    drive_op(2'd1, 32'h00000104, 32'h0, 32'h0, 5'd3, 1'b0);
    exp_q.push_back({5'd3, 32'hCAFEF00D});
    tick();
    ex_en = 1'b0;
    vectors++;
    if ({bus_rw, bus_addr} !== {1'b1, 30'h41}) begin
      miscompares++;
      $display("[TB] FAIL load_bus: got rw=%b addr=%h, required rw=1 addr=41", bus_rw, bus_addr);
    end
    for (int k = 0; k < 3; k++) begin
      if (bus_req === 1'b1) req_cycles++;
      if (mem_busy === 1'b1) busy_cycles++;
      bus_rdy = (k == 2);
      bus_rd_data = (k == 2) ? 32'hCAFEF00D : 32'hDEADBEEF;
      tick();
    end
    bus_rdy = 1'b0;
    vectors++;
    if ({req_cycles, busy_cycles} !== {32'd3, 32'd3}) begin
      miscompares++;
      $display("[TB] FAIL load_hold: got req=%0d busy=%0d cycles, required 3 and 3", req_cycles, busy_cycles);
    end
    vectors++;
    if ({bus_req, mem_busy, gpr_we_} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL load_done: got req/busy/we_=%b, required 000", {bus_req, mem_busy, gpr_we_});
    end
    tick();
    check_drained("load");
  endtask

  task automatic test_store();
    drive_op(2'd2, 32'h00000200, 32'hA5A5A5A5, 32'h0, 5'd6, 1'b0);
    tick();
    ex_en = 1'b0;
    vectors++;
    if ({bus_req, bus_rw, bus_addr, bus_wr_data} !== {1'b1, 1'b0, 30'h80, 32'hA5A5A5A5}) begin
      miscompares++;
      $display("[TB] FAIL store_bus: got req=%b rw=%b addr=%h data=%h, required 1 0 80 a5a5a5a5",
               bus_req, bus_rw, bus_addr, bus_wr_data);
    end
    bus_rdy = 1'b1;
    tick();
    bus_rdy = 1'b0;
    vectors++;
    if ({bus_req, mem_busy, gpr_we_} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL store_done: got req/busy/we_=%b, required 001", {bus_req, mem_busy, gpr_we_});
    end
    tick();
    check_drained("store");
  endtask

  task automatic test_misalign();
    drive_op(2'd1, 32'h00000103, 32'h0, 32'h0, 5'd7, 1'b0);
    tick();
    ex_en = 1'b0;
    vectors++;
    if ({mem_miss_align, bus_req, mem_busy, gpr_we_} !== 4'b1001) begin
      miscompares++;
      $display("[TB] FAIL misalign_pulse: got miss/req/busy/we_=%b, required 1001",
               {mem_miss_align, bus_req, mem_busy, gpr_we_});
    end
    tick();
    vectors++;
    if ({mem_miss_align, bus_req} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL misalign_clear: got miss/req=%b, required 00", {mem_miss_align, bus_req});
    end
    check_drained("misalign");
  endtask

  task automatic test_flush();
    // Flush in IDLE blocks acceptance
    drive_op(2'd0, 32'h0, 32'h0, 32'h0BADF00D, 5'd8, 1'b0);
    flush = 1'b1;
    tick();
    ex_en = 1'b0;
    flush = 1'b0;
    tick();
    check_drained("flush_idle");
    // Flush during ACCESS cancels only the load writeback
    drive_op(2'd1, 32'h00000040, 32'h0, 32'h0, 5'd9, 1'b0);
    tick();
    ex_en = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if ({bus_req, mem_busy} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL flush_no_abort: got req/busy=%b, required 11", {bus_req, mem_busy});
    end
    bus_rdy = 1'b1;
    bus_rd_data = 32'h11112222;
    tick();
    bus_rdy = 1'b0;
    vectors++;
    if ({bus_req, mem_busy, gpr_we_} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL flush_cancel: got req/busy/we_=%b, required 001", {bus_req, mem_busy, gpr_we_});
    end
    drive_op(2'd0, 32'h0, 32'h0, 32'h000055AA, 5'd10, 1'b0);
    exp_q.push_back({5'd10, 32'h000055AA});
    tick();
    ex_en = 1'b0;
    tick();
    check_drained("flush_after");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      drive_op(2'd0, 32'h0, 32'h0, d, 5'(i + 11), 1'b0);
      exp_q.push_back({5'(i + 11), d});
      tick();
    end
    // A NOP with a write request of 1 must not write
    drive_op(2'd0, 32'h0, 32'h0, 32'hFFFF0000, 5'd20, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      drive_op(2'd1, 32'(i * 4 + 32'h1000), 32'h0, 32'h0, 5'(i + 21), 1'b0);
      exp_q.push_back({5'(i + 21), d});
      tick();
      ex_en = 1'b0;
      vectors++;
      if ({bus_req, mem_busy, bus_addr} !== {1'b1, 1'b1, 30'(i + 32'h400)}) begin
        miscompares++;
        $display("[TB] FAIL b2b_load%0d: got req=%b busy=%b addr=%h, required 1 1 %h",
                 i, bus_req, mem_busy, bus_addr, 30'(i + 32'h400));
      end
      bus_rdy = 1'b1;
      bus_rd_data = d;
      tick();
      bus_rdy = 1'b0;
    end
    tick();
    check_drained("b2b");
  endtask

  task automatic test_reset_mid_access();
    drive_op(2'd1, 32'h00000300, 32'h0, 32'h0, 5'd4, 1'b0);
    tick();
    ex_en = 1'b0;
    vectors++;
    if (bus_req !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_req: got %b, required 1", bus_req);
    end
    reset = 1'b1;
    flush = 1'b1;
    bus_rdy = 1'b1;
    bus_rd_data = 32'h77777777;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    bus_rdy = 1'b0;
    vectors++;
    if ({bus_req, bus_rw, bus_addr, bus_wr_data, gpr_we_, gpr_wr_addr, gpr_wr_data,
         mem_miss_align, mem_busy} !== RESET_VEC) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_values: got %h, required %h",
               {bus_req, bus_rw, bus_addr, bus_wr_data, gpr_we_, gpr_wr_addr, gpr_wr_data,
                mem_miss_align, mem_busy}, RESET_VEC);
    end
    tick();
    check_drained("rst_mid");
  endtask

  initial begin
    test_reset();
    test_nop();
    test_load();
    test_store();
    test_misalign();
    test_flush();
    test_back_to_back();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
